// File: rtl/task1_sbox_init_if.sv
// Init handshake and write bus shared by the top-level sequencer, the init block and the S-box RAM.
// The sequencer is the master (drives en); the init block is the slave (drives rdy and the write bus).
interface task1_sbox_init_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic              rdy;
    logic              wren;
    logic [7:0]        addr;
    logic [DATA_W-1:0] wrdata;

    modport master (output en, input rdy, wren, addr, wrdata);
    modport slave  (input en, output rdy, wren, addr, wrdata);
endinterface

// File: rtl/task1_sbox_init.sv
// RC4 S-box initialisation top level: fills a 256x8 RAM with s[i] = i once per reset, done flag on LEDR[0].
// Optional macro TASK1_HEX_DEBUG_EN shows the current fill address on HEX1:HEX0.

module task1_s_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 8
) (
    input  logic [7:0]        address,
    input  logic              clock,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end
endmodule

module task1_init #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [7:0]        addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] i;

    // i parks at 255 in DONE so the 255 -> 0 wrap never happens and the last address stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == FILL && i != 8'hFF) begin
                i <= i + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = FILL;
            FILL:    if (i == 8'hFF) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy  = 1'b1;
        wren = 1'b0;
        if (state == FILL) begin
            rdy  = 1'b0;
            wren = 1'b1;
        end
    end

    assign addr   = i;
    assign wrdata = DATA_W'(i);
endmodule

module task1_ctrl (
    input  logic  clk,
    input  logic  rst,
    task1_sbox_init_if.master bus,
    output logic  done
);
    logic fired;

    // A single en pulse per reset; done latches on the edge that commits the final (address 255) write.
    always_ff @(posedge clk) begin
        if (rst) begin
            fired  <= 1'b0;
            bus.en <= 1'b0;
            done   <= 1'b0;
        end else begin
            bus.en <= !fired && bus.rdy;
            if (bus.rdy) begin
                fired <= 1'b1;
            end
            if (bus.wren && bus.addr == 8'hFF) begin
                done <= 1'b1;
            end
        end
    end
endmodule

module task1_sbox_init #(
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 8
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    logic              rst;
    logic              done;
    logic [DATA_W-1:0] q;
    logic              unused_bits;

    assign rst = ~KEY[3];

    task1_sbox_init_if #(.DATA_W(DATA_W)) bus ();

    task1_ctrl ctrl (
        .clk  (CLOCK_50),
        .rst  (rst),
        .bus  (bus.master),
        .done (done)
    );

    task1_init #(.DATA_W(DATA_W)) pop (
        .clk    (CLOCK_50),
        .rst    (rst),
        .en     (bus.en),
        .rdy    (bus.rdy),
        .addr   (bus.addr),
        .wrdata (bus.wrdata),
        .wren   (bus.wren)
    );

    task1_s_mem #(.MEM_DEPTH(MEM_DEPTH), .DATA_W(DATA_W)) s (
        .address (bus.addr),
        .clock   (CLOCK_50),
        .data    (bus.wrdata),
        .wren    (bus.wren),
        .q       (q)
    );

    assign LEDR        = {9'd0, done};
    assign unused_bits = ^{KEY[2:0], SW, q};

`ifdef TASK1_HEX_DEBUG_EN
    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    assign HEX0 = hex_seg(bus.addr[3:0]);
    assign HEX1 = hex_seg(bus.addr[7:4]);
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
`endif
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
endmodule

// File: tb/tb_task1_sbox_init.sv
// Bench for task1_sbox_init: table of fill/abort scenarios with random SW activity, checked against
// an expected-memory model and the write sequence 0..255.
`timescale 1ns/1ps
module tb_task1_sbox_init;
    logic       clk = 1'b0;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    always #10 clk = ~clk;

    task1_sbox_init dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    task1_sbox_init_if mon ();
    assign mon.en     = dut.pop.en;
    assign mon.rdy    = dut.pop.rdy;
    assign mon.wren   = dut.pop.wren;
    assign mon.addr   = dut.pop.addr;
    assign mon.wrdata = dut.pop.wrdata;

    typedef struct {
        int abort_at;
        int exp_writes;
        bit exp_done;
    } vec_t;

    vec_t vecs[6];
    int   exp_mem[256];
    int   n_pass   = 0;
    int   n_checks = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        SW = 10'($urandom);
    endtask

    task automatic check_mem(input string name);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (exp_mem[k] >= 0) begin
                v = dut.s.mem[k];
                if ($isunknown(v) || int'(v) != exp_mem[k]) bad++;
            end
        end
        check(name, bad, 0);
    endtask

    task automatic check_hex_blank(input string name);
        int blank;
        blank = (HEX2 == 7'h7F && HEX3 == 7'h7F && HEX4 == 7'h7F && HEX5 == 7'h7F) ? 1 : 0;
`ifndef TASK1_HEX_DEBUG_EN
        if (HEX0 != 7'h7F || HEX1 != 7'h7F) blank = 0;
`endif
        check(name, blank, 1);
    endtask

    task automatic hold_reset(input int n);
        KEY = 4'h7;
        tick();
        check("rst_rdy", int'(mon.rdy), 1);
        check("rst_wren", int'(mon.wren), 0);
        check("rst_en", int'(mon.en), 0);
        check("rst_addr", int'(mon.addr), 0);
        check("rst_ledr", int'(LEDR), 0);
`ifdef TASK1_HEX_DEBUG_EN
        check("rst_hex0", int'(HEX0), 'h40);
        check("rst_hex1", int'(HEX1), 'h40);
`endif
        check_hex_blank("rst_hex_blank");
        for (int c = 1; c < n; c++) tick();
        KEY = 4'hF;
    endtask

    task automatic run_fill(input int abort_at, output int writes, output int fall,
                            output int rise, output int bad_order, output int hex_bad);
        int q[$];
        for (int k = 0; k < 256; k++) q.push_back(k);
        writes = 0; fall = -1; rise = -1; bad_order = 0; hex_bad = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
`ifndef TASK1_HEX_DEBUG_EN
            if (HEX0 != 7'h7F || HEX1 != 7'h7F) hex_bad++;
`endif
            if (mon.wren) begin
                if (q.size() == 0 || int'(mon.addr) != q[0] || mon.wrdata != mon.addr) bad_order++;
                if (q.size() > 0) void'(q.pop_front());
                writes++;
            end
            if (fall < 0 && !mon.rdy) fall = c;
            if (fall > 0 && rise < 0 && mon.rdy) begin
                rise = c;
                break;
            end
            if (abort_at >= 0 && writes == abort_at) begin
                KEY = 4'h7;
                tick();
                check("abort_wren", int'(mon.wren), 0);
                check("abort_ledr0", int'(LEDR[0]), 0);
                check("abort_rdy", int'(mon.rdy), 1);
                break;
            end
        end
    endtask

    initial begin
        int writes, fall, rise, bad_order, hex_bad, first_rise, r, wr_cnt, rdy_low, led_low;
        KEY = 4'h7;
        SW  = 10'd0;
        first_rise = -1;
        for (int k = 0; k < 256; k++) exp_mem[k] = -1;

        r = int'($urandom_range(2, 254));
        vecs[0] = '{100, 100, 1'b0};
        vecs[1] = '{-1, 256, 1'b1};
        vecs[2] = '{1, 1, 1'b0};
        vecs[3] = '{255, 255, 1'b0};
        vecs[4] = '{r, r, 1'b0};
        vecs[5] = '{-1, 256, 1'b1};

        for (int v = 0; v < 6; v++) begin
            hold_reset(10);
            run_fill(vecs[v].abort_at, writes, fall, rise, bad_order, hex_bad);
            check("write_count", writes, vecs[v].exp_writes);
            check("write_order", bad_order, 0);
`ifndef TASK1_HEX_DEBUG_EN
            check("hex_blank_during_fill", hex_bad, 0);
`endif
            if (vecs[v].exp_done) begin
                check("rdy_fall_in_2", int'(fall >= 1 && fall <= 2), 1);
                check("rdy_rise_in_259", int'(rise > 0 && rise <= 259), 1);
                if (first_rise < 0) first_rise = rise;
                else check("timing_same_with_sw", rise, first_rise);
                tick();
                check("done_ledr0", int'(LEDR[0]), 1);
                check("done_ledr_hi", int'(LEDR[9:1]), 0);
`ifdef TASK1_HEX_DEBUG_EN
                check("done_hex0", int'(HEX0), 'h0E);
                check("done_hex1", int'(HEX1), 'h0E);
`endif
                check_hex_blank("done_hex_blank");
            end
            for (int k = 0; k < writes && k < 256; k++) exp_mem[k] = k;
            check_mem("mem_contents");
        end

        // Hold in DONE: no second run may start.
        wr_cnt = 0; rdy_low = 0; led_low = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (mon.wren) wr_cnt++;
            if (!mon.rdy) rdy_low++;
            if (!LEDR[0]) led_low++;
        end
        check("norerun_wren", wr_cnt, 0);
        check("norerun_rdy", rdy_low, 0);
        check("norerun_ledr0", led_low, 0);
        check_mem("norerun_mem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
